// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared definitions for the UART receive controller: frame
//               tracker state encoding, legal prescale values, reset
//               configuration defaults and the FIFO entry layout.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Frame tracker states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FRAME = 2'd1,
    ST_GUARD = 2'd2
  } state_t;

  // Legal oversampling ratios accepted by UART_RX
  localparam logic [5:0] PRESCALE_8  = 6'd8;
  localparam logic [5:0] PRESCALE_16 = 6'd16;
  localparam logic [5:0] PRESCALE_32 = 6'd32;

  // Configuration applied out of reset
  localparam logic       DEF_PAR_EN   = 1'b1;
  localparam logic       DEF_PAR_TYP  = 1'b1;
  localparam logic [5:0] DEF_PRESCALE = PRESCALE_8;

  // FIFO entry: {data[7:0], par_err, stp_err}
  localparam int ENTRY_W = 10;

  // Frame timer must hold (10 + 1 + 1) * 32 = 384
  localparam int TIMER_W = 10;

  function automatic logic prescale_legal(input logic [5:0] p);
    return (p == PRESCALE_8) || (p == PRESCALE_16) || (p == PRESCALE_32);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo
// Description : Synchronous FIFO holding received frames. A push while full
//               is accepted only if a pop happens in the same cycle. The head
//               output reads as zero while the FIFO is empty.
// Ports       : clk, rst_n  - clock, asynchronous active-low reset
//               push, din   - write request and entry
//               pop         - read request (ignored when empty)
//               dout        - head entry (0 when empty)
//               full, empty - occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_pop;
  logic             do_push;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_CNT);
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot this push needs.
  assign do_push = push & (~full | do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  // Storage needs no reset: the head is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_ctrl
// Description : Sequencer for a UART receiver. Owns PAR_EN / PAR_TYP /
//               prescale and changes them only between frames, tracks frame
//               activity with a timeout, buffers completed frames in a FIFO
//               for a valid/ready consumer and keeps error statistics.
// Ports       : cfg_*        - configuration request, pending/reject status
//               rx_in        - serial line, used for frame start/guard
//               rx_*         - result pulses from UART_RX
//               uart_*       - configuration driven into UART_RX
//               out_*        - FIFO head, valid/ready handshake
//               overflow, err_cnt, stat_clr - statistics and their clear
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_wr,
  input  logic             cfg_par_en,
  input  logic             cfg_par_typ,
  input  logic [5:0]       cfg_prescale,
  output logic             cfg_pending,
  output logic             cfg_rej,
  input  logic             rx_in,
  input  logic [7:0]       rx_p_data,
  input  logic             rx_data_valid,
  input  logic             rx_par_err,
  input  logic             rx_stp_err,
  output logic             uart_par_en,
  output logic             uart_par_typ,
  output logic [5:0]       uart_prescale,
  output logic [7:0]       out_data,
  output logic             out_perr,
  output logic             out_serr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overflow,
  output logic [CNT_W-1:0] err_cnt,
  input  logic             stat_clr
);

  state_t               state;
  logic [TIMER_W-1:0]   timer;
  logic [5:0]           guard_cnt;
  logic                 sh_par_en;
  logic                 sh_par_typ;
  logic [5:0]           sh_prescale;

  logic                 ev;
  logic                 pop;
  logic                 timeout;
  logic                 apply;
  logic                 cfg_legal;
  logic                 err_inc;
  logic                 drop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [ENTRY_W-1:0]   head;
  logic [3:0]           nb_plus1;
  logic [TIMER_W-1:0]   timer_load;

  assign ev  = rx_data_valid | rx_par_err | rx_stp_err;
  assign pop = out_valid & out_ready;

  // Frame budget: (start + 8 data + stop + optional parity + 1 slack) bits.
  assign nb_plus1   = 4'd11 + {3'b000, uart_par_en};
  assign timer_load = {6'b000000, nb_plus1} * {4'b0000, uart_prescale};

  // The last count of the frame timer with no frame-end seen.
  assign timeout = (state == ST_FRAME) && !ev && (timer == TIMER_W'(1));

  assign apply     = (state == ST_IDLE) && rx_in && cfg_pending;
  assign cfg_legal = prescale_legal(cfg_prescale);

  assign err_inc = (ev & (rx_par_err | rx_stp_err)) | timeout;
  assign drop    = ev & fifo_full & ~pop;

  // --------------------------------------------------------------------------
  // Frame tracker
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      timer     <= '0;
      guard_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!rx_in) begin
            state <= ST_FRAME;
            timer <= timer_load;
          end
        end
        ST_FRAME: begin
          if (ev || (timer == TIMER_W'(1))) begin
            state     <= ST_GUARD;
            guard_cnt <= '0;
          end else begin
            timer <= timer - TIMER_W'(1);
          end
        end
        ST_GUARD: begin
          // A full bit-time of idle-high is required before the next frame.
          if (!rx_in) begin
            guard_cnt <= '0;
          end else if (guard_cnt == (uart_prescale - 6'd1)) begin
            state     <= ST_IDLE;
            guard_cnt <= '0;
          end else begin
            guard_cnt <= guard_cnt + 6'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Configuration shadow and apply
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uart_par_en   <= DEF_PAR_EN;
      uart_par_typ  <= DEF_PAR_TYP;
      uart_prescale <= DEF_PRESCALE;
      sh_par_en     <= DEF_PAR_EN;
      sh_par_typ    <= DEF_PAR_TYP;
      sh_prescale   <= DEF_PRESCALE;
      cfg_pending   <= 1'b0;
      cfg_rej       <= 1'b0;
    end else begin
      cfg_rej <= cfg_wr & ~cfg_legal;
      if (apply) begin
        uart_par_en   <= sh_par_en;
        uart_par_typ  <= sh_par_typ;
        uart_prescale <= sh_prescale;
        cfg_pending   <= 1'b0;
      end
      // A write coinciding with apply is kept for the next gap.
      if (cfg_wr && cfg_legal) begin
        sh_par_en   <= cfg_par_en;
        sh_par_typ  <= cfg_par_typ;
        sh_prescale <= cfg_prescale;
        cfg_pending <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Statistics
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
      err_cnt  <= '0;
    end else if (stat_clr) begin
      overflow <= 1'b0;
      err_cnt  <= '0;
    end else begin
      if (err_inc && (err_cnt != {CNT_W{1'b1}})) begin
        err_cnt <= err_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Frame FIFO
  // --------------------------------------------------------------------------
  uart_rx_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (ev),
    .pop   (pop),
    .din   ({rx_p_data, rx_par_err, rx_stp_err}),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign out_valid = ~fifo_empty;
  assign out_data  = head[9:2];
  assign out_perr  = head[1];
  assign out_serr  = head[0];

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_ctrl
// Description : Self-checking bench for uart_rx_ctrl. A behavioural model
//               (queue-based FIFO, countdown-based frame tracker) predicts
//               every output each cycle; directed scenarios add literal
//               expectations, followed by a randomized phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_ctrl;

  localparam int DEPTH = 4;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cfg_wr = 1'b0;
  logic             cfg_par_en = 1'b0;
  logic             cfg_par_typ = 1'b0;
  logic [5:0]       cfg_prescale = 6'd0;
  logic             cfg_pending;
  logic             cfg_rej;
  logic             rx_in = 1'b1;
  logic [7:0]       rx_p_data = 8'd0;
  logic             rx_data_valid = 1'b0;
  logic             rx_par_err = 1'b0;
  logic             rx_stp_err = 1'b0;
  logic             uart_par_en;
  logic             uart_par_typ;
  logic [5:0]       uart_prescale;
  logic [7:0]       out_data;
  logic             out_perr;
  logic             out_serr;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             overflow;
  logic [CNT_W-1:0] err_cnt;
  logic             stat_clr = 1'b0;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;
  bit rnd_ready = 1'b0;

  uart_rx_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfg_wr        (cfg_wr),
    .cfg_par_en    (cfg_par_en),
    .cfg_par_typ   (cfg_par_typ),
    .cfg_prescale  (cfg_prescale),
    .cfg_pending   (cfg_pending),
    .cfg_rej       (cfg_rej),
    .rx_in         (rx_in),
    .rx_p_data     (rx_p_data),
    .rx_data_valid (rx_data_valid),
    .rx_par_err    (rx_par_err),
    .rx_stp_err    (rx_stp_err),
    .uart_par_en   (uart_par_en),
    .uart_par_typ  (uart_par_typ),
    .uart_prescale (uart_prescale),
    .out_data      (out_data),
    .out_perr      (out_perr),
    .out_serr      (out_serr),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .overflow      (overflow),
    .err_cnt       (err_cnt),
    .stat_clr      (stat_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures < 40)
        $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Behavioural model
  // --------------------------------------------------------------------------
  int         m_mode;      // 0 between frames, 1 inside a frame, 2 waiting for idle bit
  int         m_left;      // frame cycles remaining before timeout
  int         m_run;       // consecutive high cycles seen after a frame
  bit         m_pe, m_pt, m_spe, m_spt, m_pend, m_rej, m_ovf;
  int         m_ps, m_sps, m_err;
  logic [9:0] m_q[$];
  bit         t_ev, t_pop, t_tmo, t_drop, t_legal, t_apply;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_left = 0; m_run = 0;
      m_pe = 1; m_pt = 1; m_ps = 8;
      m_spe = 1; m_spt = 1; m_sps = 8;
      m_pend = 0; m_rej = 0; m_ovf = 0; m_err = 0;
      m_q.delete();
    end else begin
      t_ev    = rx_data_valid | rx_par_err | rx_stp_err;
      t_pop   = (m_q.size() != 0) && out_ready;
      t_tmo   = 0;
      t_drop  = 0;
      t_legal = (cfg_prescale == 8) || (cfg_prescale == 16) || (cfg_prescale == 32);
      t_apply = (m_mode == 0) && rx_in && m_pend;
      m_rej = cfg_wr && !t_legal;
      if (t_apply) begin
        m_pe = m_spe; m_pt = m_spt; m_ps = m_sps; m_pend = 0;
      end
      if (cfg_wr && t_legal) begin
        m_spe = cfg_par_en; m_spt = cfg_par_typ; m_sps = int'(cfg_prescale); m_pend = 1;
      end
      case (m_mode)
        0: if (!rx_in) begin
             m_mode = 1;
             m_left = (11 + int'(m_pe)) * m_ps;
           end
        1: if (t_ev) begin
             m_mode = 2; m_run = 0;
           end else begin
             m_left--;
             if (m_left == 0) begin
               t_tmo = 1; m_mode = 2; m_run = 0;
             end
           end
        default: if (!rx_in) m_run = 0;
                 else begin
                   m_run++;
                   if (m_run == m_ps) m_mode = 0;
                 end
      endcase
      if (t_pop) void'(m_q.pop_front());
      if (t_ev) begin
        if (m_q.size() < DEPTH) m_q.push_back({rx_p_data, rx_par_err, rx_stp_err});
        else t_drop = 1;
      end
      if (stat_clr) begin
        m_err = 0; m_ovf = 0;
      end else begin
        if (((t_ev && (rx_par_err || rx_stp_err)) || t_tmo) && m_err < 255) m_err++;
        if (t_drop) m_ovf = 1;
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    logic [9:0] h;
    if (chk_en) begin
      h = (m_q.size() != 0) ? m_q[0] : 10'd0;
      check("uart_par_en",   32'(uart_par_en),   32'(m_pe));
      check("uart_par_typ",  32'(uart_par_typ),  32'(m_pt));
      check("uart_prescale", 32'(uart_prescale), 32'(m_ps));
      check("cfg_pending",   32'(cfg_pending),   32'(m_pend));
      check("cfg_rej",       32'(cfg_rej),       32'(m_rej));
      check("out_valid",     32'(out_valid),     32'(m_q.size() != 0));
      check("out_head",      32'({out_data, out_perr, out_serr}), 32'(h));
      check("overflow",      32'(overflow),      32'(m_ovf));
      check("err_cnt",       32'(err_cnt),       32'(m_err));
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic pulse_cfg(input bit pe, input bit pt, input logic [5:0] ps);
    cfg_par_en = pe; cfg_par_typ = pt; cfg_prescale = ps; cfg_wr = 1'b1;
    tick(1);
    cfg_wr = 1'b0;
  endtask

  // Serial frame at the currently applied configuration; cfg_wr (with the
  // cfg_* values already set) is pulsed at the start of data bit cfg_at.
  task automatic send_frame(input logic [7:0] d, input bit pe, input bit se, input int cfg_at);
    int ps;
    bit pen;
    ps  = m_ps;
    pen = m_pe;
    rx_in = 1'b0;
    tick(ps);
    for (int i = 0; i < 8; i++) begin
      rx_in = d[i];
      if (i == cfg_at) begin
        cfg_wr = 1'b1; tick(1); cfg_wr = 1'b0; tick(ps - 1);
      end else begin
        tick(ps);
      end
    end
    if (pen) begin
      rx_in = 1'($urandom_range(0, 1));
      tick(ps);
    end
    rx_in = 1'b1;
    tick(ps / 2);
    rx_p_data = d; rx_data_valid = !(pe || se); rx_par_err = pe; rx_stp_err = se;
    tick(1);
    rx_data_valid = 1'b0; rx_par_err = 1'b0; rx_stp_err = 1'b0;
    tick(ps + 2);
  endtask

  // --------------------------------------------------------------------------
  // Main sequence
  // --------------------------------------------------------------------------
  initial begin
    logic [5:0] ps_tab [6];
    ps_tab[0] = 6'd8; ps_tab[1] = 6'd16; ps_tab[2] = 6'd32;
    ps_tab[3] = 6'd12; ps_tab[4] = 6'd0; ps_tab[5] = 6'd63;

    // Reset defaults
    tick(3);
    chk_en = 1'b1;
    check("rst_prescale", 32'(uart_prescale), 32'd8);
    check("rst_par_en",   32'(uart_par_en),   32'd1);
    check("rst_par_typ",  32'(uart_par_typ),  32'd1);
    check("rst_valid",    32'(out_valid),     32'd0);
    rst_n = 1'b1;
    tick(2);

    // Basic frame and pop
    send_frame(8'hA5, 1'b0, 1'b0, -1);
    check("frame_valid", 32'(out_valid), 32'd1);
    check("frame_data",  32'(out_data),  32'hA5);
    out_ready = 1'b1; tick(1); out_ready = 1'b0;
    check("pop_valid", 32'(out_valid), 32'd0);

    // Config written mid-frame applied only after the guard interval
    cfg_par_en = 1'b0; cfg_par_typ = 1'b1; cfg_prescale = 6'd16;
    send_frame(8'h3C, 1'b0, 1'b0, 1);
    check("apply_prescale", 32'(uart_prescale), 32'd16);
    check("apply_par_en",   32'(uart_par_en),   32'd0);
    check("apply_pending",  32'(cfg_pending),   32'd0);
    out_ready = 1'b1; tick(1); out_ready = 1'b0;

    // Illegal prescale rejected
    pulse_cfg(1'b1, 1'b0, 6'd12);
    check("rej_pulse",    32'(cfg_rej),       32'd1);
    check("rej_prescale", 32'(uart_prescale), 32'd16);
    check("rej_pending",  32'(cfg_pending),   32'd0);
    tick(1);
    check("rej_clear", 32'(cfg_rej), 32'd0);

    // Overflow with five frames, then full + pop + push accepted
    for (int i = 1; i <= 5; i++) send_frame(8'(i * 8'h11), 1'b0, 1'b0, -1);
    check("ovf_set",  32'(overflow), 32'd1);
    check("ovf_head", 32'(out_data), 32'h11);
    stat_clr = 1'b1; tick(1); stat_clr = 1'b0;
    check("ovf_clr", 32'(overflow), 32'd0);
    rx_p_data = 8'h3C; rx_data_valid = 1'b1; out_ready = 1'b1;
    tick(1);
    rx_data_valid = 1'b0; out_ready = 1'b0;
    check("fullpop_ovf",  32'(overflow), 32'd0);
    check("fullpop_head", 32'(out_data), 32'h22);
    out_ready = 1'b1; tick(6); out_ready = 1'b0;
    check("drain_valid", 32'(out_valid), 32'd0);

    // Timeout at prescale 8 with parity: 96 clocks
    pulse_cfg(1'b1, 1'b1, 6'd8);
    tick(2);
    check("to_prescale", 32'(uart_prescale), 32'd8);
    rx_in = 1'b0;
    tick(96);
    check("to_before", 32'(err_cnt), 32'd0);
    tick(1);
    check("to_after", 32'(err_cnt), 32'd1);
    check("to_fifo",  32'(out_valid), 32'd0);
    rx_in = 1'b1;
    pulse_cfg(1'b1, 1'b1, 6'd16);
    tick(3);
    check("guard_hold", 32'(cfg_pending), 32'd1);
    tick(10);
    check("guard_done", 32'(cfg_pending), 32'd0);
    stat_clr = 1'b1; tick(1); stat_clr = 1'b0;
    check("clr_err", 32'(err_cnt), 32'd0);

    // Saturation: error pulses while idle
    rx_par_err = 1'b1;
    tick(260);
    rx_par_err = 1'b0;
    check("sat_err", 32'(err_cnt), 32'd255);
    stat_clr = 1'b1; tick(1); stat_clr = 1'b0;
    out_ready = 1'b1; tick(5); out_ready = 1'b0;

    // Reset mid-frame with FIFO entries and a pending config
    send_frame(8'h01, 1'b0, 1'b0, -1);
    send_frame(8'h02, 1'b0, 1'b1, -1);
    rx_in = 1'b0;
    tick(5);
    pulse_cfg(1'b0, 1'b0, 6'd32);
    tick(3);
    check("pre_rst_pending", 32'(cfg_pending), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_pending",  32'(cfg_pending),   32'd0);
    check("rst_mid_prescale", 32'(uart_prescale), 32'd8);
    check("rst_mid_valid",    32'(out_valid),     32'd0);
    check("rst_mid_err",      32'(err_cnt),       32'd0);
    rx_in = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    send_frame(8'h5A, 1'b0, 1'b0, -1);
    check("post_rst_data", 32'(out_data), 32'h5A);
    out_ready = 1'b1; tick(1); out_ready = 1'b0;

    // Randomized phase
    rnd_ready = 1'b1;
    for (int n = 0; n < 50; n++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 6) begin
        cfg_par_en = 1'($urandom_range(0, 1));
        cfg_par_typ = 1'($urandom_range(0, 1));
        cfg_prescale = ps_tab[$urandom_range(0, 5)];
        send_frame(8'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                   int'($urandom_range(0, 11)) - 3);
      end else if (r == 6) begin
        pulse_cfg(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ps_tab[$urandom_range(0, 5)]);
        tick(2);
      end else if (r == 7) begin
        rx_in = 1'b0;
        tick((11 + int'(m_pe)) * m_ps + 3);
        rx_in = 1'b1;
        tick(m_ps + 2);
      end else if (r == 8) begin
        rx_p_data = 8'($urandom); rx_data_valid = 1'b1;
        rx_stp_err = 1'($urandom_range(0, 1));
        tick(1);
        rx_data_valid = 1'b0; rx_stp_err = 1'b0;
        tick(1);
      end else begin
        stat_clr = 1'b1; tick(1); stat_clr = 1'b0;
      end
    end
    rnd_ready = 1'b0;
    out_ready = 1'b1;
    tick(8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
